// File: rtl/button_debouncer_pkg.sv
// Shared types and sizing helpers for the push-button debouncer.
package button_debouncer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    // One spare bit above the largest terminal count keeps every compare in range.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs, synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button into a clean level plus press, auto-repeat and release pulses.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic button,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_active
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btn_sync;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button_raw),
        .q   (btn_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            button        <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state       <= PRESSED;
                        button      <= 1'b1;
                        press_pulse <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end else if ((REPEAT_DELAY != 0) && (cnt == DLY_LAST)) begin
                        state         <= REPEAT;
                        repeat_active <= 1'b1;
                        press_pulse   <= 1'b1;
                        cnt           <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!btn_sync) begin
                        state         <= RELEASE_WAIT;
                        repeat_active <= 1'b0;
                        cnt           <= CNT_ONE;
                    end else if (cnt == PER_LAST) begin
                        press_pulse <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    // A return to 1 cancels the release and restarts repeat timing.
                    if (btn_sync) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state         <= IDLE;
                        button        <= 1'b0;
                        release_pulse <= 1'b1;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    button        <= 1'b0;
                    repeat_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus randomized bouncing against a run-length model.
module tb_button_debouncer;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button_raw = 1'b0;
    logic button, press_pulse, release_pulse, repeat_active;

    int checks = 0;
    int passes = 0;

    // Reference model: two-sample input delay, then run-length debounce and hold-time repeat.
    logic m_s1, m_s2, m_btn;
    int   m_diff, m_since;
    logic exp_press, exp_rel, exp_rep;
    logic [3:0] expv, obs;

    // Stand-in for the edge-sensitive digit counter consumer.
    logic   prev_pulse;
    int     digit;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button_raw    (button_raw),
        .button        (button),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_active (repeat_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            digit      <= 1;
            prev_pulse <= 1'b0;
        end else begin
            prev_pulse <= press_pulse;
            if (press_pulse && !prev_pulse) digit <= (digit == 3) ? 1 : digit + 1;
        end
    end

    assign obs = {button, press_pulse, release_pulse, repeat_active};

    task automatic applyStimulus(input logic raw_val, input logic rst_val);
        logic s;
        button_raw = raw_val;
        rst        = rst_val;
        @(posedge clk);
        exp_press = 1'b0;
        exp_rel   = 1'b0;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_btn = 1'b0; m_diff = 0; m_since = 0;
        end else begin
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = button_raw;
            if (s != m_btn) begin
                m_diff++;
                if (m_diff == DEB) begin
                    m_btn   = !m_btn;
                    m_diff  = 0;
                    m_since = 0;
                    if (m_btn) exp_press = 1'b1;
                    else       exp_rel   = 1'b1;
                end
            end else begin
                if (m_btn && m_diff > 0) begin
                    m_since = 0;
                end else if (m_btn) begin
                    m_since++;
                    if (RD != 0 && m_since >= RD && ((m_since - RD) % RP) == 0) exp_press = 1'b1;
                end
                m_diff = 0;
            end
        end
        exp_rep = m_btn && (m_diff == 0) && (RD != 0) && (m_since >= RD);
        expv    = {m_btn, exp_press, exp_rel, exp_rep};
        @(negedge clk);
    endtask

    task automatic test_reset;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checks++;
        if (obs !== 4'b0000) $display("[TB] FAIL reset_outputs got=%b exp=%b", obs, 4'b0000);
        else passes++;
        applyStimulus(1'b0, 1'b0);
        checks++;
        if (obs !== expv) $display("[TB] FAIL reset_model got=%b exp=%b", obs, expv);
        else passes++;
    endtask

    task automatic test_clean_press;
        int first, n;
        first = -1; n = 0;
        applyStimulus(1'b0, 1'b1);
        for (int e = 0; e < 20; e++) begin
            applyStimulus(e < 12, 1'b0);
            checks++;
            if (obs !== expv) $display("[TB] FAIL clean_model edge=%0d got=%b exp=%b", e, obs, expv);
            else passes++;
            if (e < 12 && press_pulse) begin
                n++;
                if (first < 0) first = e;
            end
            if (e == 5 || e == 11) begin
                checks++;
                if (button !== 1'b1) $display("[TB] FAIL clean_level edge=%0d got=%b exp=1", e, button);
                else passes++;
            end
        end
        checks++;
        if (n != 1 || first != 5) $display("[TB] FAIL clean_press_edge got=%0d pulses first=%0d exp=1 pulse first=5", n, first);
        else passes++;
    endtask

    task automatic test_bounce;
        logic [26:0] pat;
        logic seen;
        pat  = 27'b000_0000_0000_0000_0000_0110_111;
        seen = 1'b0;
        applyStimulus(1'b0, 1'b1);
        for (int e = 0; e < 27; e++) begin
            applyStimulus(pat[e], 1'b0);
            checks++;
            if (obs !== expv) $display("[TB] FAIL bounce_model edge=%0d got=%b exp=%b", e, obs, expv);
            else passes++;
            if (button || press_pulse || release_pulse) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL bounce_reject got=%b exp=0", seen);
        else passes++;
    endtask

    task automatic test_auto_repeat;
        int got[$];
        int want[$];
        int rep_first;
        want = '{5, 15, 20, 25, 30};
        rep_first = -1;
        applyStimulus(1'b0, 1'b1);
        for (int e = 0; e < 42; e++) begin
            applyStimulus(e < 32, 1'b0);
            checks++;
            if (obs !== expv) $display("[TB] FAIL repeat_model edge=%0d got=%b exp=%b", e, obs, expv);
            else passes++;
            if (e < 32 && press_pulse) got.push_back(e);
            if (repeat_active && rep_first < 0) rep_first = e;
        end
        checks++;
        if (got != want) $display("[TB] FAIL repeat_edges got=%p exp=%p", got, want);
        else passes++;
        checks++;
        if (rep_first != 15) $display("[TB] FAIL repeat_active_start got=%0d exp=15", rep_first);
        else passes++;
    endtask

    task automatic test_release_glitch;
        int rel_first;
        rel_first = -1;
        applyStimulus(1'b0, 1'b1);
        for (int e = 0; e < 30; e++) begin
            applyStimulus(!((e == 12) || (e == 13) || (e >= 18)), 1'b0);
            checks++;
            if (obs !== expv) $display("[TB] FAIL glitch_model edge=%0d got=%b exp=%b", e, obs, expv);
            else passes++;
            if (release_pulse && rel_first < 0) rel_first = e;
            if (e == 17) begin
                checks++;
                if (button !== 1'b1) $display("[TB] FAIL glitch_hold got=%b exp=1", button);
                else passes++;
            end
        end
        checks++;
        if (rel_first != 23) $display("[TB] FAIL release_edge got=%0d exp=23", rel_first);
        else passes++;
    endtask

    task automatic test_reset_mid_repeat;
        int first;
        logic rel_seen;
        first = -1; rel_seen = 1'b0;
        applyStimulus(1'b0, 1'b1);
        for (int e = 0; e < 17; e++) applyStimulus(1'b1, 1'b0);
        checks++;
        if (repeat_active !== 1'b1) $display("[TB] FAIL pre_reset_repeat got=%b exp=1", repeat_active);
        else passes++;
        applyStimulus(1'b1, 1'b1);
        checks++;
        if (obs !== 4'b0000) $display("[TB] FAIL mid_reset_outputs got=%b exp=%b", obs, 4'b0000);
        else passes++;
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b1, 1'b0);
            checks++;
            if (obs !== expv) $display("[TB] FAIL rearm_model edge=%0d got=%b exp=%b", j, obs, expv);
            else passes++;
            if (press_pulse && first < 0) first = j;
            if (release_pulse) rel_seen = 1'b1;
        end
        checks++;
        if (first != 5 || rel_seen) $display("[TB] FAIL rearm_press got=%0d rel=%b exp=5 rel=0", first, rel_seen);
        else passes++;
    endtask

    task automatic test_integration;
        int want[4];
        want = '{2, 3, 1, 2};
        applyStimulus(1'b0, 1'b1);
        checks++;
        if (digit != 1) $display("[TB] FAIL digit_reset got=%0d exp=1", digit);
        else passes++;
        for (int p = 0; p < 4; p++) begin
            for (int e = 0; e < 20; e++) applyStimulus(e < 8, 1'b0);
            checks++;
            if (digit != want[p]) $display("[TB] FAIL digit_press%0d got=%0d exp=%0d", p, digit, want[p]);
            else passes++;
        end
    endtask

    task automatic test_random;
        logic lvl;
        int   run;
        lvl = 1'b0;
        run = 0;
        applyStimulus(1'b0, 1'b1);
        for (int e = 0; e < 800; e++) begin
            if (run == 0) begin
                lvl = !lvl;
                run = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 30) : $urandom_range(1, 5);
            end
            run--;
            applyStimulus(lvl, $urandom_range(0, 199) == 0);
            checks++;
            if (obs !== expv) $display("[TB] FAIL random_model edge=%0d got=%b exp=%b", e, obs, expv);
            else passes++;
            if (press_pulse && release_pulse) begin
                checks++;
                $display("[TB] FAIL pulse_exclusive edge=%0d got=11 exp=not both", e);
            end
        end
    endtask

    initial begin
        m_s1 = 1'b0; m_s2 = 1'b0; m_btn = 1'b0; m_diff = 0; m_since = 0;
        exp_press = 1'b0; exp_rel = 1'b0; exp_rep = 1'b0; expv = 4'b0000;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_glitch();
        test_reset_mid_repeat();
        test_integration();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
